// File: rtl/addition_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addition_pkg
//  Description : Shared definitions for the adder-kernel result serializer:
//                default lane geometry, lane-index width helper and the
//                serializer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package addition_pkg;

  // Default geometry of one result vector produced by the adder kernel.
  localparam int LANES_DEF   = 8;
  localparam int WIDTH_DEF   = 8;
  localparam int COUNT_W_DEF = 16;

  // Width of an index that selects one lane out of LANES lanes.
  // Never returns less than 1 so that a 1-bit index still exists.
  function automatic int lane_idx_width(input int lanes);
    return (lanes < 2) ? 1 : $clog2(lanes);
  endfunction

  localparam int LANE_IDX_W = lane_idx_width(LANES_DEF);

  // IDLE: nothing buffered, ready for a vector.
  // SEND: a captured vector is being emitted lane by lane.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage : addition_pkg
`default_nettype wire

// File: rtl/addition_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : addition_result_serializer
//  Description : Captures one LANES x WIDTH result vector through a
//                valid/ready handshake and replays it lane by lane (lane 0
//                first) on a WIDTH-bit valid/ready stream with a last flag.
//                A new vector may be captured on the last-beat cycle of the
//                current one, giving gap-free back-to-back streaming.
//
//  Ports       : clk        - sole clock, rising edge
//                rst        - synchronous active-high reset
//                in_data    - result vector, lane i at [i*WIDTH +: WIDTH]
//                in_valid   - in_data holds a valid vector
//                in_ready   - vector is accepted this cycle
//                out_data   - current lane value (zero when idle)
//                out_valid  - out_data is valid
//                out_ready  - downstream accepts out_data
//                out_last   - current beat is lane LANES-1
//                vec_count  - number of fully emitted vectors (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module addition_result_serializer
  import addition_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [COUNT_W-1:0]     vec_count
);

  localparam int                  c_IDX_W    = lane_idx_width(LANES);
  localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(LANES - 1);

  // --------------------------------------------------------------------------
  // State and next-state signals
  // --------------------------------------------------------------------------
  ser_state_t               r_state;
  ser_state_t               w_state_nxt;
  logic [c_IDX_W-1:0]       r_lane_idx;
  logic [c_IDX_W-1:0]       w_lane_idx_nxt;
  logic [LANES*WIDTH-1:0]   r_buffer;
  logic [LANES*WIDTH-1:0]   w_buffer_nxt;
  logic [COUNT_W-1:0]       r_vec_count;
  logic [COUNT_W-1:0]       w_vec_count_nxt;

  logic [WIDTH-1:0]         w_lanes [LANES];
  logic                     w_send;
  logic                     w_at_last;
  logic                     w_capture;
  logic                     w_beat;

  // --------------------------------------------------------------------------
  // Lane view of the buffer, so the output mux is a plain array index.
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lanes
      assign w_lanes[g] = r_buffer[g*WIDTH +: WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign w_send    = (r_state == SEND);
  assign w_at_last = (r_lane_idx == c_LAST_IDX);

  assign out_valid = w_send;
  assign out_last  = w_send && w_at_last;
  assign out_data  = w_send ? w_lanes[r_lane_idx] : '0;

  // Ready either when empty, or when the final beat of the current vector
  // leaves this very cycle; the out_ready -> in_ready combinational path is
  // what removes the bubble between consecutive vectors.
  assign in_ready  = !rst && (!w_send || (w_at_last && out_ready));

  assign w_capture = in_valid && in_ready;
  assign w_beat    = w_send && out_ready;

  assign vec_count = r_vec_count;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_lane_idx_nxt  = r_lane_idx;
    w_buffer_nxt    = r_buffer;
    w_vec_count_nxt = r_vec_count;

    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_buffer_nxt   = in_data;
          w_lane_idx_nxt = '0;
          w_state_nxt    = SEND;
        end
      end

      SEND: begin
        if (w_beat) begin
          if (!w_at_last) begin
            w_lane_idx_nxt = r_lane_idx + c_IDX_W'(1);
          end else begin
            w_vec_count_nxt = r_vec_count + COUNT_W'(1);
            w_lane_idx_nxt  = '0;
            if (w_capture) begin
              // Reload on the last beat and keep streaming.
              w_buffer_nxt = in_data;
              w_state_nxt  = SEND;
            end else begin
              w_state_nxt  = IDLE;
            end
          end
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_lane_idx_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lane_idx  <= '0;
      r_buffer    <= '0;
      r_vec_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane_idx  <= w_lane_idx_nxt;
      r_buffer    <= w_buffer_nxt;
      r_vec_count <= w_vec_count_nxt;
    end
  end

endmodule : addition_result_serializer
`default_nettype wire
